io_out_demux: RTL
=================

IO_OUT_DEMUX -- requirements
Module: io_out_demux

Interface
REQ-001 Parameter PORT_LEDS, default 8'h40, port ID of the LED output register.
REQ-002 Parameter PORT_SSEG, default 8'h81, port ID of the seven-segment output register.
REQ-003 Parameter PORT_AUX, default 8'h42, port ID of the auxiliary output register.
REQ-004 Parameter PORT_TXQ, default 8'h50, port ID of the transmit queue.
REQ-005 Parameter TXQ_DEPTH, default 4, queue entries; power of two, 2..16.
REQ-006 CLK  in  1  sole clock; all state updates on rising edge.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 PORT_ID  in  8  target port of the current CPU write.
REQ-009 OUT_PORT  in  8  CPU write data.
REQ-010 IO_STRB  in  1  one-cycle write strobe from CPU.
REQ-011 LEDS  out  8  LED register.
REQ-012 SSEG  out  8  seven-segment register.
REQ-013 AUX  out  8  auxiliary register.
REQ-014 UPD  out  3  one-cycle update pulses {AUX,SSEG,LEDS}.
REQ-015 TX_DATA  out  8  queue head byte.
REQ-016 TX_VALID  out  1  queue non-empty.
REQ-017 TX_READY  in  1  consumer accepts head when high with TX_VALID.
REQ-018 TXQ_COUNT  out  $clog2(TXQ_DEPTH)+1  occupied entries.
REQ-019 TXQ_FULL  out  1  count equals TXQ_DEPTH.
REQ-020 OVF  out  1  sticky overflow flag.
REQ-021 OVF_CLR  in  1  clears OVF.

Function
REQ-022 Write decode: IO_STRB high and PORT_ID matching a register ID SHALL load OUT_PORT into that register at the same edge; value visible the following cycle.
REQ-023 UPD bit of the written register SHALL pulse high exactly one cycle, the cycle after the write edge.
REQ-024 IO_STRB with unmatched PORT_ID, or IO_STRB low, SHALL change no state.
REQ-025 Push: IO_STRB with PORT_ID==PORT_TXQ SHALL enqueue OUT_PORT when not full; TX_VALID rises the cycle after push to an empty queue.
REQ-026 TX_DATA SHALL present the head entry combinationally from storage (first-word fall-through), stable while TX_VALID high and TX_READY low.
REQ-027 Pop: TX_VALID and TX_READY high at an edge SHALL remove the head; TX_DATA advances next cycle.
REQ-028 Push and pop same edge, queue not empty: both occur, count unchanged, including when full.
REQ-029 Push to full queue without simultaneous pop: byte dropped, contents unchanged, OVF set next cycle.
REQ-030 OVF SHALL remain high until OVF_CLR sampled high; overflow and OVF_CLR same edge: OVF stays set.
REQ-031 Read/write pointers SHALL wrap modulo TXQ_DEPTH; count arithmetic never exceeds TXQ_DEPTH nor underflows.
REQ-032 TX_READY with queue empty SHALL have no effect.
REQ-033 Queue states EMPTY (count 0), PARTIAL, FULL (count TXQ_DEPTH); transitions only by REQ-025/027/028.

Reset
REQ-034 RST_N low SHALL immediately force LEDS, SSEG, AUX, UPD, TXQ_COUNT, OVF to 0 and pointers to 0; TX_VALID 0, TXQ_FULL 0.
REQ-035 Reset mid-operation SHALL discard queued bytes; queue storage need not be cleared.
REQ-036 First write honoured at the first rising edge after RST_N deasserts.

Structure
REQ-037 Port ID defaults SHALL live in shared package io_pkg, also used by the CPU top level.
REQ-038 Queue SHALL be a sub-module sync_fifo (parameterised width/depth, FWFT, count/full outputs); decode, registers, UPD and OVF in io_out_demux.

Verification
REQ-039 Reset; strobe PORT_ID=8'h40, OUT_PORT=8'hA5 -> LEDS=8'hA5 next cycle, UPD=3'b001 one cycle, SSEG/AUX remain 0.
REQ-040 Strobe PORT_ID=8'h77, OUT_PORT=8'hFF -> no output, UPD, or count change.
REQ-041 TX_READY=0; push 8'h01..8'h04 -> TXQ_COUNT=4, TXQ_FULL=1, TX_DATA=8'h01; push 8'h05 -> dropped, OVF=1; OVF_CLR pulse -> OVF=0.
REQ-042 Full queue, push 8'h06 with TX_READY=1 same edge -> count stays 4, pops read 8'h02,8'h03,8'h04,8'h06.
REQ-043 Push 6 bytes with TX_READY=1 continuously -> drained in order, pointers wrap, TX_VALID falls after last byte.
REQ-044 Queue holding 3 bytes, LEDS=8'h3C; assert RST_N=0 mid-cycle -> all outputs 0 immediately; after release TX_VALID=0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared IO port map and transmit-queue types, also used by the CPU top level.
package io_pkg;

  localparam logic [7:0] PORT_LEDS_DEF = 8'h40;
  localparam logic [7:0] PORT_SSEG_DEF = 8'h81;
  localparam logic [7:0] PORT_AUX_DEF  = 8'h42;
  localparam logic [7:0] PORT_TXQ_DEF  = 8'h50;
  localparam int         TXQ_DEPTH_DEF = 4;

  // Bit positions inside the UPD pulse vector {AUX,SSEG,LEDS}.
  localparam int UPD_LEDS = 0;
  localparam int UPD_SSEG = 1;
  localparam int UPD_AUX  = 2;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } txq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; the occupancy state is exported as state_o.
module sync_fifo
  import io_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   overflow_o,
  output txq_state_e             state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  txq_state_e    state_q, state_d;
  logic          do_push, do_pop;

  // Handshake: the head is transferred at an edge where state is not EMPTY and
  // pop_i is high; a push while FULL is accepted only if a pop frees a slot at
  // the same edge, otherwise the byte is dropped and overflow_o is raised.
  always_comb begin
    do_pop     = pop_i && (state_q != Q_EMPTY);
    do_push    = push_i && ((state_q != Q_FULL) || do_pop);
    overflow_o = push_i && (state_q == Q_FULL) && !do_pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
    if (count_d == '0)          state_d = Q_EMPTY;
    else if (count_d == DEPTH_C) state_d = Q_FULL;
    else                         state_d = Q_PARTIAL;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= Q_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (state_q == Q_FULL);
  assign state_o   = state_q;

endmodule

// File: rtl/io_out_demux.sv
// CPU output-port decoder: LED/7-seg/AUX registers with update pulses, plus a
// transmit byte queue with a sticky overflow flag.
module io_out_demux
  import io_pkg::*;
#(
  parameter logic [7:0] PORT_LEDS = PORT_LEDS_DEF,
  parameter logic [7:0] PORT_SSEG = PORT_SSEG_DEF,
  parameter logic [7:0] PORT_AUX  = PORT_AUX_DEF,
  parameter logic [7:0] PORT_TXQ  = PORT_TXQ_DEF,
  parameter int         TXQ_DEPTH = TXQ_DEPTH_DEF
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [7:0]                 PORT_ID,
  input  logic [7:0]                 OUT_PORT,
  input  logic                       IO_STRB,
  output logic [7:0]                 LEDS,
  output logic [7:0]                 SSEG,
  output logic [7:0]                 AUX,
  output logic [2:0]                 UPD,
  output logic [7:0]                 TX_DATA,
  output logic                       TX_VALID,
  input  logic                       TX_READY,
  output logic [$clog2(TXQ_DEPTH):0] TXQ_COUNT,
  output logic                       TXQ_FULL,
  output logic                       OVF,
  input  logic                       OVF_CLR
);

  logic [7:0] leds_q, leds_d;
  logic [7:0] sseg_q, sseg_d;
  logic [7:0] aux_q, aux_d;
  logic [2:0] upd_q, upd_d;
  logic       ovf_q, ovf_d;
  logic       txq_push, txq_ovf;
  txq_state_e txq_state;

  always_comb begin
    leds_d   = leds_q;
    sseg_d   = sseg_q;
    aux_d    = aux_q;
    upd_d    = '0;
    ovf_d    = ovf_q;
    txq_push = IO_STRB && (PORT_ID == PORT_TXQ);
    if (IO_STRB && (PORT_ID == PORT_LEDS)) begin
      leds_d          = OUT_PORT;
      upd_d[UPD_LEDS] = 1'b1;
    end
    if (IO_STRB && (PORT_ID == PORT_SSEG)) begin
      sseg_d          = OUT_PORT;
      upd_d[UPD_SSEG] = 1'b1;
    end
    if (IO_STRB && (PORT_ID == PORT_AUX)) begin
      aux_d          = OUT_PORT;
      upd_d[UPD_AUX] = 1'b1;
    end
    // A fresh overflow wins over a clear sampled at the same edge.
    if (OVF_CLR) ovf_d = 1'b0;
    if (txq_ovf) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      leds_q <= '0;
      sseg_q <= '0;
      aux_q  <= '0;
      upd_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      sseg_q <= sseg_d;
      aux_q  <= aux_d;
      upd_q  <= upd_d;
      ovf_q  <= ovf_d;
    end
  end

  sync_fifo #(
    .W     (8),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .push_i     (txq_push),
    .wr_data_i  (OUT_PORT),
    .pop_i      (TX_READY),
    .rd_data_o  (TX_DATA),
    .count_o    (TXQ_COUNT),
    .full_o     (TXQ_FULL),
    .overflow_o (txq_ovf),
    .state_o    (txq_state)
  );

  assign TX_VALID = (txq_state != Q_EMPTY);
  assign LEDS     = leds_q;
  assign SSEG     = sseg_q;
  assign AUX      = aux_q;
  assign UPD      = upd_q;
  assign OVF      = ovf_q;

endmodule
